apb_master: RTL
===============

Name: apb_master

Overview:
- APB3 requester (initiator) driving a single APB completer, e.g. the I2C bridge slave.
- Accepts one read/write command at a time on a valid/ready command port and runs the SETUP/ACCESS phases.
- Returns read data and error status on a valid/ready response port.
- Serves as the bench-side and SoC-side driver for the I2C register block, and includes a wait-state timeout so that a stalled completer cannot hang the initiator.

Parameters:
- ADDR_W, 32, width of PADDR and cmd_addr.
- DATA_W, 32, width of PWDATA/PRDATA and data fields.
- TIMEOUT_CYCLES, 255, maximum ACCESS wait cycles with PREADY low before abort; 0 disables the timeout.

Ports:
- PCLK  in  1  clock.
- PRESETn  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted this cycle when cmd_valid=1.
- cmd_write  in  1  1=write, 0=read.
- cmd_addr  in  ADDR_W  target address.
- cmd_wdata  in  DATA_W  write data.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  DATA_W  read data (0 for writes and timeouts).
- rsp_err  out  1  PSLVERR sampled at completion, or timeout.
- rsp_timeout  out  1  transfer aborted by timeout.
- busy  out  1  state != IDLE.
- PSELx  out  1  APB select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB direction.
- PADDR  out  ADDR_W  APB address.
- PWDATA  out  DATA_W  APB write data.
- PRDATA  in  DATA_W  APB read data.
- PREADY  in  1  completer ready.
- PSLVERR  in  1  completer error.

Behaviour:
- Reset (async assert, sync deassert inside PCLK domain): state=IDLE; PSELx, PENABLE, PWRITE, rsp_valid, rsp_err and rsp_timeout all 0; PADDR, PWDATA and rsp_rdata all 0; wait counter 0.
- All APB outputs and rsp_* are registered. cmd_ready = (state==IDLE) and is combinational from state only, never from cmd_valid.
- States:
  - IDLE: on cmd_valid & cmd_ready, register PADDR, PWRITE and PWDATA (PWDATA captured even for reads), set PSELx=1, go to SETUP.
  - SETUP: PSELx=1, PENABLE=0. Exactly one cycle, then set PENABLE=1 and go to ACCESS.
  - ACCESS: PSELx=PENABLE=1. PADDR, PWRITE and PWDATA stay stable for the whole phase. Each cycle with PREADY=0, the wait counter increments.
    - On PREADY=1: rsp_rdata = PWRITE ? 0 : PRDATA; rsp_err = PSLVERR; rsp_timeout = 0. Clear PSELx/PENABLE and the counter. rsp_valid=1. Go to RESP.
    - On timeout (TIMEOUT_CYCLES != 0, counter == TIMEOUT_CYCLES and PREADY=0): rsp_rdata=0, rsp_err=1, rsp_timeout=1. Clear PSELx/PENABLE and the counter. rsp_valid=1. Go to RESP.
    - PREADY=1 in the same cycle the counter reaches the limit counts as a normal completion; PREADY has priority.
  - RESP: rsp_valid held with rsp_* stable until rsp_ready=1, then rsp_valid=0 and go to IDLE.
- Latency:
  - Zero-wait transfer: command accept at cycle N, SETUP at N+1, ACCESS at N+2, rsp_valid at N+3.
  - Minimum command-to-command spacing is 4 cycles.
- Counter width = clog2(TIMEOUT_CYCLES+1); minimum 1 bit.
- PSLVERR and PRDATA are ignored in every cycle except an ACCESS cycle with PREADY=1.
- PADDR and PWDATA retain their last values when idle; PSELx=0 makes them don't-care on the bus.
- An asynchronous reset in any state immediately drops PSELx/PENABLE and discards any pending response.
- Commands arriving while busy are held off by cmd_ready=0; the requester must keep cmd_* stable until accepted.

Decomposition:
- Package apb_master_pkg holds:
  - state enum {IDLE, SETUP, ACCESS, RESP};
  - localparams for the APB address map used by benches: TX_FIFO=0, RX_FIFO=4, CONFIG=8, TIMEOUT=12;
  - a response struct {rdata, err, timeout}.
- No sub-module. Timeout counter and FSM live in one module.

Test Plan:
- Write cmd_addr=8, wdata=0x0000_1ABC; completer PREADY=1 in first ACCESS -> PSELx for 2 cycles, PENABLE in cycle 2 only; rsp_valid at accept+3 with rsp_err=0 and rsp_rdata=0.
- Read addr=4; completer inserts 3 wait states, then PRDATA=0xDEAD_BEEF -> PADDR stable for all 5 APB cycles; rsp_rdata=0xDEAD_BEEF; rsp_valid at accept+6.
- Read addr=4 with PREADY=1 and PSLVERR=1 -> rsp_err=1, rsp_timeout=0; PSLVERR pulsed in a wait cycle (PREADY=0) beforehand has no effect.
- TIMEOUT_CYCLES=4, PREADY held 0 -> abort after 4 wait cycles; rsp_err=1, rsp_timeout=1, rsp_rdata=0; PSELx=0 thereafter. Repeat with PREADY=1 on the 4th wait cycle -> normal completion.
- Back-to-back: cmd_valid held high for two commands, rsp_ready=0 for 3 cycles -> cmd_ready=0 until the response is consumed; second SETUP begins 1 cycle after rsp_ready; no APB activity while in RESP.
- Assert PRESETn=0 mid-ACCESS -> PSELx, PENABLE and rsp_valid go to 0 without waiting for PCLK; after release, cmd_ready=1 and the next transfer completes normally.

Source files
------------

// File: rtl/apb_master_pkg.sv
// Shared types for the APB3 requester: FSM states, response record and the
// register map of the I2C bridge completer it normally drives.
package apb_master_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      ACCESS,
      RESP
   } state_e;

   localparam logic [31:0] TX_FIFO = 32'd0;
   localparam logic [31:0] RX_FIFO = 32'd4;
   localparam logic [31:0] CONFIG  = 32'd8;
   localparam logic [31:0] TIMEOUT = 32'd12;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
      logic        timeout;
   } rsp_t;

endpackage

// File: rtl/apb_master.sv
// APB3 requester: one command at a time through SETUP/ACCESS, with a wait-state
// timeout so a stalled completer cannot hang the initiator.
module apb_master
   import apb_master_pkg::*;
#(
   parameter int unsigned ADDR_W         = 32,
   parameter int unsigned DATA_W         = 32,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic              PCLK,
   input  logic              PRESETn,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              rsp_timeout,
   output logic              busy,
   output logic              PSELx,
   output logic              PENABLE,
   output logic              PWRITE,
   output logic [ADDR_W-1:0] PADDR,
   output logic [DATA_W-1:0] PWDATA,
   input  logic [DATA_W-1:0] PRDATA,
   input  logic              PREADY,
   input  logic              PSLVERR
);

   localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);
   localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

   state_e            state_q, state_d;
   logic              psel_q, psel_d;
   logic              penable_q, penable_d;
   logic              pwrite_q, pwrite_d;
   logic [ADDR_W-1:0] paddr_q, paddr_d;
   logic [DATA_W-1:0] pwdata_q, pwdata_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
   logic              rsp_err_q, rsp_err_d;
   logic              rsp_timeout_q, rsp_timeout_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   always_comb begin
      state_d       = state_q;
      psel_d        = psel_q;
      penable_d     = penable_q;
      pwrite_d      = pwrite_q;
      paddr_d       = paddr_q;
      pwdata_d      = pwdata_q;
      rsp_valid_d   = rsp_valid_q;
      rsp_rdata_d   = rsp_rdata_q;
      rsp_err_d     = rsp_err_q;
      rsp_timeout_d = rsp_timeout_q;
      cnt_d         = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               paddr_d  = cmd_addr;
               pwrite_d = cmd_write;
               pwdata_d = cmd_wdata;
               psel_d   = 1'b1;
               state_d  = SETUP;
            end
         end
         SETUP: begin
            penable_d = 1'b1;
            state_d   = ACCESS;
         end
         ACCESS: begin
            // PREADY wins over an expiring counter in the same cycle.
            if (PREADY) begin
               rsp_rdata_d   = pwrite_q ? '0 : PRDATA;
               rsp_err_d     = PSLVERR;
               rsp_timeout_d = 1'b0;
               psel_d        = 1'b0;
               penable_d     = 1'b0;
               cnt_d         = '0;
               rsp_valid_d   = 1'b1;
               state_d       = RESP;
            end else if (TIMEOUT_EN && (cnt_q == CNT_LIMIT)) begin
               rsp_rdata_d   = '0;
               rsp_err_d     = 1'b1;
               rsp_timeout_d = 1'b1;
               psel_d        = 1'b0;
               penable_d     = 1'b0;
               cnt_d         = '0;
               rsp_valid_d   = 1'b1;
               state_d       = RESP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state_q       <= IDLE;
         psel_q        <= 1'b0;
         penable_q     <= 1'b0;
         pwrite_q      <= 1'b0;
         paddr_q       <= '0;
         pwdata_q      <= '0;
         rsp_valid_q   <= 1'b0;
         rsp_rdata_q   <= '0;
         rsp_err_q     <= 1'b0;
         rsp_timeout_q <= 1'b0;
         cnt_q         <= '0;
      end else begin
         state_q       <= state_d;
         psel_q        <= psel_d;
         penable_q     <= penable_d;
         pwrite_q      <= pwrite_d;
         paddr_q       <= paddr_d;
         pwdata_q      <= pwdata_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_rdata_q   <= rsp_rdata_d;
         rsp_err_q     <= rsp_err_d;
         rsp_timeout_q <= rsp_timeout_d;
         cnt_q         <= cnt_d;
      end
   end

   assign cmd_ready   = (state_q == IDLE);
   assign busy        = (state_q != IDLE);
   assign PSELx       = psel_q;
   assign PENABLE     = penable_q;
   assign PWRITE      = pwrite_q;
   assign PADDR       = paddr_q;
   assign PWDATA      = pwdata_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_rdata   = rsp_rdata_q;
   assign rsp_err     = rsp_err_q;
   assign rsp_timeout = rsp_timeout_q;

endmodule
